// File: rtl/mem_dump.sv
// Sequential memory dump engine: reads word_count words starting at base_addr
// from a ready-handshaked memory unit and streams (address, data) pairs downstream.
`ifndef MEMORY_ADDR_WIDTH
`define MEMORY_ADDR_WIDTH 16
`endif
`ifndef MEMORY_DATA_WIDTH
`define MEMORY_DATA_WIDTH 16
`endif

module mem_dump #(
    parameter logic [1:0] FUNC_READ = 2'b00
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [`MEMORY_ADDR_WIDTH-1:0] base_addr,
    input  logic [`MEMORY_ADDR_WIDTH-1:0] word_count,
    input  logic                          mem_ready,
    input  logic [`MEMORY_DATA_WIDTH-1:0] read_data1,
    output logic                          mem_execute,
    output logic [1:0]                    mem_func,
    output logic [`MEMORY_ADDR_WIDTH-1:0] address1,
    output logic                          dout_valid,
    output logic [`MEMORY_DATA_WIDTH-1:0] dout_data,
    output logic [`MEMORY_ADDR_WIDTH-1:0] dout_addr,
    input  logic                          dout_ready,
    output logic                          busy,
    output logic                          done,
    output logic [2:0]                    dbg_state
);

    localparam int AW = `MEMORY_ADDR_WIDTH;
    localparam int DW = `MEMORY_DATA_WIDTH;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_LOW  = 3'd2,
        WAIT_HIGH = 3'd3,
        OUT       = 3'd4,
        FIN       = 3'd5
    } state_t;

    state_t        state;
    logic [AW-1:0] cur_addr;
    logic [AW-1:0] remaining;

    // Downstream handshake: a word transfers on any rising edge where
    // dout_valid && dout_ready; dout_valid/data/addr are held stable until then.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cur_addr   <= '0;
            remaining  <= '0;
            dout_valid <= 1'b0;
            dout_data  <= '0;
            dout_addr  <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (word_count != '0) begin
                            cur_addr  <= base_addr;
                            remaining <= word_count;
                            state     <= ISSUE;
                        end else begin
                            state <= FIN;
                        end
                    end
                end
                ISSUE: begin
                    if (mem_ready) state <= WAIT_LOW;
                end
                WAIT_LOW: begin
                    if (!mem_ready) state <= WAIT_HIGH;
                end
                WAIT_HIGH: begin
                    if (mem_ready) begin
                        dout_data  <= read_data1;
                        dout_addr  <= cur_addr;
                        dout_valid <= 1'b1;
                        state      <= OUT;
                    end
                end
                OUT: begin
                    if (dout_ready) begin
                        dout_valid <= 1'b0;
                        remaining  <= remaining - 1'b1;
                        cur_addr   <= cur_addr + 1'b1;
                        state      <= (remaining == AW'(1)) ? FIN : ISSUE;
                    end
                end
                FIN: begin
                    // Clearing cur_addr here keeps address1 at zero while idle.
                    done      <= 1'b1;
                    cur_addr  <= '0;
                    remaining <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The request strobe follows mem_ready so it is only ever high in the issue cycle.
    assign mem_execute = (state == ISSUE) && mem_ready && !rst;
    assign mem_func    = FUNC_READ;
    assign address1    = cur_addr;
    assign busy        = (state != IDLE);
    assign dbg_state   = state;

    logic unused_dw;
    assign unused_dw = (DW > 0);

endmodule

// File: tb/tb_mem_dump.sv
// Scoreboard bench for mem_dump: stimulus pushes expected (addr, data) pairs,
// an independent monitor pops and compares on every downstream transfer.
`ifndef MEMORY_ADDR_WIDTH
`define MEMORY_ADDR_WIDTH 16
`endif
`ifndef MEMORY_DATA_WIDTH
`define MEMORY_DATA_WIDTH 16
`endif

module tb_mem_dump;
    localparam int AW = `MEMORY_ADDR_WIDTH;
    localparam int DW = `MEMORY_DATA_WIDTH;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] word_count;
    logic          mem_ready;
    logic [DW-1:0] read_data1 = '0;
    logic          mem_execute;
    logic [1:0]    mem_func;
    logic [AW-1:0] address1;
    logic          dout_valid;
    logic [DW-1:0] dout_data;
    logic [AW-1:0] dout_addr;
    logic          dout_ready = 1'b1;
    logic          busy;
    logic          done;
    logic [2:0]    dbg_state;

    always #5 clk = ~clk;

    mem_dump #(.FUNC_READ(2'b00)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .word_count(word_count), .mem_ready(mem_ready), .read_data1(read_data1),
        .mem_execute(mem_execute), .mem_func(mem_func), .address1(address1),
        .dout_valid(dout_valid), .dout_data(dout_data), .dout_addr(dout_addr),
        .dout_ready(dout_ready), .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    int total = 0;
    int bad   = 0;
    logic [AW+DW-1:0] exp_q[$];
    int exec_cnt = 0;
    int done_cnt = 0;

    // memory model: ready drops for low_len cycles after each request
    logic          mdl_ready = 1'b1;
    logic          hold_low  = 1'b0;
    int            low_len   = 1;
    int            low_left  = 0;
    bit            issue_seen = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    assign mem_ready = mdl_ready && !hold_low;

    bit bp_mode = 1'b0;
    int stall   = 0;

    bit            held = 1'b0;
    logic [DW-1:0] hold_data;
    logic [AW-1:0] hold_addr;

    function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
        logic [31:0] t;
        t = 32'(a) + 32'h100;
        return t[DW-1:0];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (issue_seen) begin
            issue_seen = 1'b0;
            mdl_ready  = 1'b0;
            low_left   = low_len;
        end else if (low_left > 0) begin
            low_left--;
            if (low_left == 0) begin
                mdl_ready  = 1'b1;
                read_data1 = mem_val(rd_addr);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (!bp_mode) dout_ready = 1'b1;
        else if (dout_valid) begin
            if (stall < 5) begin
                dout_ready = 1'b0;
                stall++;
            end else dout_ready = 1'b1;
        end else begin
            stall      = 0;
            dout_ready = 1'b0;
        end
    end

    // monitor
    always @(negedge clk) begin
        logic [AW+DW-1:0] e;
        if (mem_execute) begin
            exec_cnt++;
            issue_seen = 1'b1;
            rd_addr    = address1;
            check("mem_func", 64'(mem_func), 64'(2'b00));
            check("exec_while_valid", 64'(dout_valid), 64'd0);
        end
        if (done) done_cnt++;
        if (dout_valid) begin
            if (held) begin
                check("stall_data", 64'(dout_data), 64'(hold_data));
                check("stall_addr", 64'(dout_addr), 64'(hold_addr));
            end
            if (dout_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got addr %0h data %0h expected none",
                             dout_addr, dout_data);
                end else begin
                    e = exp_q.pop_front();
                    check("out_addr", 64'(dout_addr), 64'(e[AW+DW-1:DW]));
                    check("out_data", 64'(dout_data), 64'(e[DW-1:0]));
                end
                held = 1'b0;
            end else begin
                held      = 1'b1;
                hold_data = dout_data;
                hold_addr = dout_addr;
            end
        end else held = 1'b0;
    end

    task automatic pulse_start(input logic [AW-1:0] b, input logic [AW-1:0] n);
        @(posedge clk); #1;
        start      = 1'b1;
        base_addr  = b;
        word_count = n;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic push_exp(input logic [AW-1:0] b, input int n);
        logic [AW-1:0] a;
        for (int i = 0; i < n; i++) begin
            a = b + AW'(i);
            exp_q.push_back({a, mem_val(a)});
        end
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!done && k < budget);
        check("done_timeout", 64'(done), 64'd1);
        @(negedge clk);
    endtask

    task automatic run_dump(input logic [AW-1:0] b, input logic [AW-1:0] n, input int exp_exec);
        int e0 = exec_cnt;
        int d0 = done_cnt;
        push_exp(b, int'(n));
        pulse_start(b, n);
        wait_done(2000);
        check("exec_count", 64'(exec_cnt - e0), 64'(exp_exec));
        check("done_count", 64'(done_cnt - d0), 64'd1);
        check("busy_after", 64'(busy), 64'd0);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #500000;
        bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        int seen;
        int k;
        rst = 1'b1; start = 1'b0; base_addr = '0; word_count = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_valid", 64'(dout_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_exec", 64'(mem_execute), 64'd0);
        check("rst_addr1", 64'(address1), 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);

        // basic dump
        run_dump(AW'(1), AW'(3), 3);

        // backpressure
        bp_mode = 1'b1;
        run_dump(AW'(1), AW'(3), 3);
        bp_mode = 1'b0;

        // zero count
        e0 = exec_cnt;
        @(posedge clk); #1;
        start = 1'b1; base_addr = AW'(9); word_count = '0;
        @(negedge clk);
        check("zero_done_c0", 64'(done), 64'd0);
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        check("zero_done_c1", 64'(done), 64'd0);
        check("zero_busy_fin", 64'(busy), 64'd1);
        @(negedge clk);
        check("zero_done_c2", 64'(done), 64'd1);
        @(negedge clk);
        check("zero_done_c3", 64'(done), 64'd0);
        check("zero_exec", 64'(exec_cnt - e0), 64'd0);
        check("zero_busy_after", 64'(busy), 64'd0);

        // wrap-around
        run_dump({AW{1'b1}} - AW'(1), AW'(3), 3);

        // start while busy is ignored
        e0 = exec_cnt;
        push_exp(AW'(1), 2);
        pulse_start(AW'(1), AW'(2));
        repeat (3) @(posedge clk);
        #1 start = 1'b1; base_addr = AW'(50); word_count = AW'(5);
        @(posedge clk); #1 start = 1'b0;
        wait_done(2000);
        repeat (10) @(negedge clk);
        check("busy_start_exec", 64'(exec_cnt - e0), 64'd2);
        check("busy_start_queue", 64'(exp_q.size()), 64'd0);
        check("busy_start_idle", 64'(busy), 64'd0);

        // ready stall, then reset in WAIT_HIGH
        e0 = exec_cnt;
        hold_low = 1'b1;
        pulse_start(AW'(20), AW'(3));
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (mem_execute) seen++;
        end
        check("stall_no_exec", 64'(seen), 64'd0);
        check("stall_in_issue", 64'(dbg_state), 64'd1);
        low_len = 4;
        @(posedge clk); #1 hold_low = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (dbg_state != 3'd3 && k < 50);
        check("reach_wait_high", 64'(dbg_state), 64'd3);
        @(posedge clk); #1;
        rst = 1'b1; start = 1'b1; base_addr = AW'(77); word_count = AW'(2);
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check("mid_rst_exec", 64'(mem_execute), 64'd0);
        check("mid_rst_valid", 64'(dout_valid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_data", 64'(dout_data), 64'd0);
        check("mid_rst_daddr", 64'(dout_addr), 64'd0);
        check("mid_rst_addr1", 64'(address1), 64'd0);
        check("mid_rst_state", 64'(dbg_state), 64'd0);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (dout_valid || mem_execute || busy) seen++;
        end
        check("post_rst_quiet", 64'(seen), 64'd0);
        check("post_rst_exec", 64'(exec_cnt - e0), 64'd1);
        low_len = 1;
        run_dump(AW'(7), AW'(2), 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
